// File: rtl/isp_fifo_pkg.sv
// Shared sizing constants for the ISP byte FIFO controller and its output stage.
package isp_fifo_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = ADDR_W + 2;
endpackage

// File: rtl/isp_fifo_out_skid.sv
// Two-entry head/skid buffer that absorbs SRAM read data so pops run back to back.
module isp_fifo_out_skid
  import isp_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              arr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        out_cnt
);

  logic [DATA_W-1:0] skid;

  // The issue logic upstream never lets an arrival land while both entries are held and not popping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_cnt <= 2'd0;
      head    <= '0;
    end else begin
      case (out_cnt)
        2'd0: begin
          if (arr) begin
            head    <= arr_data;
            out_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (pop && arr) begin
            head <= arr_data;
          end else if (pop) begin
            out_cnt <= 2'd0;
          end else if (arr) begin
            skid    <= arr_data;
            out_cnt <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            head <= skid;
            if (arr) skid <= arr_data;
            else     out_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/isp_byte_fifo_ctrl.sv
// Pointer, flag and read-prefetch control turning an external 64x8 two-port SRAM into a byte FIFO.
module isp_byte_fifo_ctrl
  import isp_fifo_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              PUSH_VALID,
  input  logic [DATA_W-1:0] PUSH_DATA,
  output logic              PUSH_READY,
  output logic              POP_VALID,
  output logic [DATA_W-1:0] POP_DATA,
  input  logic              POP_READY,
  output logic [CNT_W-1:0]  COUNT,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WD,
  output logic              RAM_WEN,
  output logic [ADDR_W-1:0] RAM_RADDR,
  output logic              RAM_REN,
  input  logic [DATA_W-1:0] RAM_RD
);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] ram_cnt;
  logic             rd_pend;
  logic [1:0]       out_cnt;
  logic [2:0]       occ;
  logic             pop_fire;

  assign ram_cnt    = wptr - rptr;
  assign PUSH_READY = (ram_cnt != PTR_W'(DEPTH));
  assign POP_VALID  = (out_cnt != 2'd0);
  assign pop_fire   = POP_VALID && POP_READY;

  assign RAM_WEN   = PUSH_VALID && PUSH_READY && !FLUSH && !RST;
  assign RAM_WADDR = wptr[ADDR_W-1:0];
  assign RAM_WD    = PUSH_DATA;

  // Occupancy of the output stage next cycle, counting the read already in flight.
  assign occ       = 3'(out_cnt) + 3'(rd_pend) - 3'(pop_fire);
  assign RAM_REN   = !RST && !FLUSH && (ram_cnt != '0) && (occ < 3'd2);
  assign RAM_RADDR = rptr[ADDR_W-1:0];

  assign COUNT = CNT_W'(ram_cnt) + CNT_W'(rd_pend) + CNT_W'(out_cnt);

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (RAM_WEN) wptr <= wptr + 1'b1;
      if (RAM_REN) rptr <= rptr + 1'b1;
      rd_pend <= RAM_REN;
    end
  end

  // Read data lands one cycle after issue; a flush in that cycle discards it.
  isp_fifo_out_skid u_out (
    .clk      (CLK),
    .rst      (RST),
    .flush    (FLUSH),
    .arr      (rd_pend),
    .arr_data (RAM_RD),
    .pop      (pop_fire),
    .head     (POP_DATA),
    .out_cnt  (out_cnt)
  );

endmodule

// File: tb/tb_isp_byte_fifo_ctrl.sv
// Scoreboard bench for isp_byte_fifo_ctrl with a behavioural 64x8 SRAM beside it.
module tb_isp_byte_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, push_valid, pop_ready;
  logic [7:0] push_data;
  logic       push_ready, pop_valid, ram_wen, ram_ren;
  logic [7:0] pop_data, ram_wd, ram_rd;
  logic [7:0] count;
  logic [5:0] ram_waddr, ram_raddr;

  logic [7:0] mem [64];
  logic [7:0] sb [$];
  logic [5:0] wp;
  logic       hold;
  logic [7:0] hold_data;
  int         checks = 0;
  int         failures = 0;
  int         n_pop = 0;

  always #5 clk = ~clk;

  isp_byte_fifo_ctrl dut (
    .CLK        (clk),
    .RST        (rst),
    .FLUSH      (flush),
    .PUSH_VALID (push_valid),
    .PUSH_DATA  (push_data),
    .PUSH_READY (push_ready),
    .POP_VALID  (pop_valid),
    .POP_DATA   (pop_data),
    .POP_READY  (pop_ready),
    .COUNT      (count),
    .RAM_WADDR  (ram_waddr),
    .RAM_WD     (ram_wd),
    .RAM_WEN    (ram_wen),
    .RAM_RADDR  (ram_raddr),
    .RAM_REN    (ram_ren),
    .RAM_RD     (ram_rd)
  );

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wd;
    if (ram_ren) ram_rd <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle monitor: handshakes observed mid-cycle, state reflected in COUNT is the queue depth.
  always @(negedge clk) begin
    if (rst || flush) begin
      if (flush && !rst) chk("wen_flush", ram_wen, 0);
      sb.delete();
      wp = '0;
      hold = 1'b0;
    end else begin
      chk("count", count, sb.size());
      if (hold) begin
        chk("hold_valid", pop_valid, 1);
        chk("hold_data", pop_data, hold_data);
      end
      chk("wen", ram_wen, push_valid && push_ready);
      if (push_valid && push_ready) begin
        chk("waddr", ram_waddr, wp);
        chk("wd", ram_wd, push_data);
      end
      if (pop_valid && pop_ready) begin
        chk("pop_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) chk("pop_data", pop_data, sb.pop_front());
        n_pop++;
      end
      if (push_valid && push_ready) begin
        sb.push_back(push_data);
        wp = wp + 6'd1;
      end
      hold = pop_valid && !pop_ready;
      hold_data = pop_data;
    end
  end

  task automatic drain();
    pop_ready  = 1'b1;
    push_valid = 1'b0;
    for (int i = 0; i < 200 && count != 0; i++) tick();
    chk("drained", count, 0);
  endtask

  initial begin
    int acc, gaps, maxcnt, pushed, seen;
    logic accepted;
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_wen", ram_wen, 0);
    chk("rst_ren", ram_ren, 0);
    chk("rst_pop_data", pop_data, 0);

    // Single byte latency
    tick();
    push_valid = 1'b1; push_data = 8'hA5; pop_ready = 1'b1;
    @(negedge clk);
    chk("single_wen", ram_wen, 1);
    chk("single_waddr", ram_waddr, 0);
    tick(); push_valid = 1'b0;
    @(negedge clk);
    chk("single_ren", ram_ren, 1);
    chk("single_raddr", ram_raddr, 0);
    chk("single_c1_valid", pop_valid, 0);
    tick(); @(negedge clk);
    chk("single_c2_valid", pop_valid, 0);
    tick(); @(negedge clk);
    chk("single_c3_valid", pop_valid, 1);
    chk("single_c3_data", pop_data, 8'hA5);
    tick(); @(negedge clk);
    chk("single_count0", count, 0);

    // Fill with the consumer stalled
    tick();
    pop_ready = 1'b0; acc = 0;
    for (int c = 0; c < 100; c++) begin
      push_valid = 1'b1; push_data = 8'(acc);
      @(negedge clk);
      accepted = push_ready;
      tick();
      if (accepted) acc++;
    end
    @(negedge clk);
    chk("fill_accepted", acc, 66);
    chk("fill_push_ready", push_ready, 0);
    chk("fill_count", count, 66);
    chk("fill_head", pop_data, 8'h00);
    tick();
    push_valid = 1'b0; pop_ready = 1'b1;
    @(negedge clk);
    tick(); pop_ready = 1'b0;
    @(negedge clk);
    chk("fill_next_head", pop_data, 8'h01);
    seen = push_ready ? 1 : 0;
    tick(); @(negedge clk);
    if (push_ready) seen = 1;
    chk("fill_ready_back", seen, 1);
    tick();
    drain();

    // Streaming through pointer wrap
    gaps = 0; maxcnt = 0;
    pop_ready = 1'b1;
    for (int c = 0; c < 303; c++) begin
      push_valid = (c < 300); push_data = 8'(c);
      @(negedge clk);
      if (c >= 3 && !pop_valid) gaps++;
      if (int'(count) > maxcnt) maxcnt = count;
      tick();
    end
    push_valid = 1'b0;
    chk("stream_gaps", gaps, 0);
    chk("stream_maxcnt_le3", maxcnt <= 3, 1);
    drain();

    // Random backpressure
    pushed = 0; hold = 1'b0; accepted = 1'b0; n_pop = 0;
    push_data = 8'($urandom);
    for (int c = 0; c < 20000 && (pushed < 1000 || count != 0); c++) begin
      if (!(push_valid && !accepted && pushed < 1000))
        push_valid = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      pop_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      accepted = push_valid && push_ready;
      tick();
      if (accepted) begin
        pushed++;
        push_data = 8'($urandom);
      end
    end
    push_valid = 1'b0;
    chk("rand_pushed", pushed, 1000);
    chk("rand_popped", n_pop, 1000);
    drain();

    // Flush with a simultaneous push
    pop_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      push_valid = 1'b1; push_data = 8'(c + 8'h40);
      tick();
    end
    push_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("flush_pre_count", count, 40);
    tick();
    flush = 1'b1; push_valid = 1'b1; push_data = 8'hFF;
    @(negedge clk);
    chk("flush_no_write", ram_wen, 0);
    tick();
    flush = 1'b0; push_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", count, 0);
    chk("flush_pop_valid", pop_valid, 0);
    tick();
    push_valid = 1'b1; push_data = 8'h11; pop_ready = 1'b1;
    tick(); push_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("flush_c2_valid", pop_valid, 0);
    tick(); @(negedge clk);
    chk("flush_c3_valid", pop_valid, 1);
    chk("flush_c3_data", pop_data, 8'h11);
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
